// File: rtl/uart_frame_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_frame_pkg
// Shared types and constants for the UART frame controller.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
package uart_frame_pkg;

  // Parser state encoding
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_CMD  = 3'd2,
    ST_LEN  = 3'd3,
    ST_DATA = 3'd4,
    ST_CHK  = 3'd5
  } state_t;

  // Abort reasons reported on err_code
  localparam logic [1:0] ERR_LEN = 2'd1;
  localparam logic [1:0] ERR_CHK = 2'd2;
  localparam logic [1:0] ERR_TMO = 2'd3;

  // Default frame header bytes
  localparam logic [7:0] HDR0_DEFAULT = 8'hAA;
  localparam logic [7:0] HDR1_DEFAULT = 8'h55;

endpackage
`default_nettype wire

// File: rtl/uart_frame_ctrl_timeout.sv
`default_nettype none
// ---------------------------------------------------------------------------
// frame_timeout
// Inter-byte cycle counter; flags expiry when the count reaches
// TIMEOUT_CYC-1 while enabled and not being cleared.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module frame_timeout #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q;

  // Count idle cycles; any clear request restarts the window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // A clear on the expiry cycle wins, so the byte is never lost
  assign expired_o = en_i && !clr_i && (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/uart_frame_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_frame_ctrl
// Parses HDR0 HDR1 CMD LEN payload CHK frames from the UART byte stream,
// checks length and checksum, enforces an inter-byte timeout and presents
// good frames with a single-cycle strobe.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module uart_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] HDR0        = HDR0_DEFAULT,
  parameter logic [7:0] HDR1        = HDR1_DEFAULT,
  parameter int         MAX_LEN     = 8,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             rx_byte,
  input  logic                   rx_valid,
  output logic [7:0]             frm_cmd,
  output logic [3:0]             frm_len,
  output logic [8*MAX_LEN-1:0]   frm_data,
  output logic                   frm_valid,
  output logic                   frm_err,
  output logic [1:0]             err_code,
  output logic                   busy
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t                 state_q, state_d;
  logic [7:0]             cmd_q, cmd_d;
  logic [3:0]             len_q, len_d;
  logic [3:0]             idx_q, idx_d;
  logic [7:0]             sum_q, sum_d;
  logic [8*MAX_LEN-1:0]   pay_q, pay_d;
  logic [7:0]             frm_cmd_q, frm_cmd_d;
  logic [3:0]             frm_len_q, frm_len_d;
  logic [8*MAX_LEN-1:0]   frm_data_q, frm_data_d;
  logic                   frm_valid_q, frm_valid_d;
  logic                   frm_err_q, frm_err_d;
  logic [1:0]             err_code_q, err_code_d;
  logic                   w_tmo_expired;

  frame_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (rx_valid || (state_q == ST_IDLE)),
    .en_i      (state_q != ST_IDLE),
    .expired_o (w_tmo_expired)
  );

  // State, shadow frame and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      sum_q       <= '0;
      pay_q       <= '0;
      frm_cmd_q   <= '0;
      frm_len_q   <= '0;
      frm_data_q  <= '0;
      frm_valid_q <= 1'b0;
      frm_err_q   <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      pay_q       <= pay_d;
      frm_cmd_q   <= frm_cmd_d;
      frm_len_q   <= frm_len_d;
      frm_data_q  <= frm_data_d;
      frm_valid_q <= frm_valid_d;
      frm_err_q   <= frm_err_d;
      err_code_q  <= err_code_d;
    end
  end

  // Frame parser: advances only on byte strobes, otherwise watches timeout
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    len_d       = len_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    pay_d       = pay_q;
    frm_cmd_d   = frm_cmd_q;
    frm_len_d   = frm_len_q;
    frm_data_d  = frm_data_q;
    frm_valid_d = 1'b0;
    frm_err_d   = 1'b0;
    err_code_d  = err_code_q;

    if (rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_byte == HDR0) state_d = ST_HDR;
        end
        ST_HDR: begin
          if (rx_byte == HDR1)      state_d = ST_CMD;
          else if (rx_byte != HDR0) state_d = ST_IDLE;
        end
        ST_CMD: begin
          cmd_d   = rx_byte;
          sum_d   = rx_byte;
          state_d = ST_LEN;
        end
        ST_LEN: begin
          if (rx_byte > MAX_LEN_B) begin
            frm_err_d  = 1'b1;
            err_code_d = ERR_LEN;
            state_d    = ST_IDLE;
          end else begin
            // Zero-length frames also latch length and clear the payload so
            // no stale data is published.
            len_d   = rx_byte[3:0];
            pay_d   = '0;
            idx_d   = '0;
            sum_d   = sum_q + rx_byte;
            state_d = (rx_byte == 8'd0) ? ST_CHK : ST_DATA;
          end
        end
        ST_DATA: begin
          for (int i = 0; i < MAX_LEN; i++) begin
            if (idx_q == 4'(i)) pay_d[i*8 +: 8] = rx_byte;
          end
          sum_d = sum_q + rx_byte;
          idx_d = idx_q + 4'd1;
          if (idx_q == len_q - 4'd1) state_d = ST_CHK;
        end
        ST_CHK: begin
          if (rx_byte == sum_q) begin
            frm_cmd_d   = cmd_q;
            frm_len_d   = len_q;
            frm_data_d  = pay_q;
            frm_valid_d = 1'b1;
          end else begin
            frm_err_d  = 1'b1;
            err_code_d = ERR_CHK;
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (w_tmo_expired) begin
      frm_err_d  = 1'b1;
      err_code_d = ERR_TMO;
      state_d    = ST_IDLE;
    end
  end

  assign frm_cmd   = frm_cmd_q;
  assign frm_len   = frm_len_q;
  assign frm_data  = frm_data_q;
  assign frm_valid = frm_valid_q;
  assign frm_err   = frm_err_q;
  assign err_code  = err_code_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_frame_ctrl
// Directed self-checking bench for uart_frame_ctrl.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_uart_frame_ctrl;

  localparam int T = 100;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic [7:0]  frm_cmd;
  logic [3:0]  frm_len;
  logic [63:0] frm_data;
  logic        frm_valid;
  logic        frm_err;
  logic [1:0]  err_code;
  logic        busy;

  int tests = 0;
  int fails = 0;

  uart_frame_ctrl #(
    .MAX_LEN     (8),
    .TIMEOUT_CYC (T)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .frm_cmd   (frm_cmd),
    .frm_len   (frm_len),
    .frm_data  (frm_data),
    .frm_valid (frm_valid),
    .frm_err   (frm_err),
    .err_code  (err_code),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One strobe; returns on the negedge after the sampling posedge
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  logic [7:0] burst [10];
  int         pulses;

  initial begin
    rst_n    = 1'b0;
    rx_byte  = 8'h00;
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", {63'd0, frm_valid}, 64'd0);
    chk("rst_err",   {63'd0, frm_err},   64'd0);
    chk("rst_cmd",   {56'd0, frm_cmd},   64'd0);
    chk("rst_data",  frm_data,           64'd0);
    chk("rst_busy",  {63'd0, busy},      64'd0);
    rst_n = 1'b1;

    // Good two-byte frame
    send_byte(8'hAA); send_byte(8'h55);
    chk("busy_mid", {63'd0, busy}, 64'd1);
    send_byte(8'h10); send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
    chk("g1_prevalid", {63'd0, frm_valid}, 64'd0);
    send_byte(8'h58);
    chk("g1_valid", {63'd0, frm_valid}, 64'd1);
    chk("g1_err",   {63'd0, frm_err},   64'd0);
    chk("g1_cmd",   {56'd0, frm_cmd},   64'h10);
    chk("g1_len",   {60'd0, frm_len},   64'd2);
    chk("g1_data",  frm_data,           64'h3412);
    chk("g1_busy",  {63'd0, busy},      64'd0);
    @(negedge clk);
    chk("g1_pulse", {63'd0, frm_valid}, 64'd0);

    // Zero-length frame
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h20); send_byte(8'h00);
    send_byte(8'h20);
    chk("z_valid", {63'd0, frm_valid}, 64'd1);
    chk("z_len",   {60'd0, frm_len},   64'd0);
    chk("z_data",  frm_data,           64'd0);
    chk("z_cmd",   {56'd0, frm_cmd},   64'h20);

    // Checksum mismatch
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h10); send_byte(8'h01);
    send_byte(8'h05); send_byte(8'h00);
    chk("c_err",   {63'd0, frm_err},   64'd1);
    chk("c_valid", {63'd0, frm_valid}, 64'd0);
    chk("c_code",  {62'd0, err_code},  64'd2);
    chk("c_cmd",   {56'd0, frm_cmd},   64'h20);
    @(negedge clk);
    chk("c_pulse", {63'd0, frm_err},   64'd0);
    chk("c_hold",  {62'd0, err_code},  64'd2);

    // Length violation, then trailing bytes ignored
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h10); send_byte(8'h09);
    chk("l_err",  {63'd0, frm_err},  64'd1);
    chk("l_code", {62'd0, err_code}, 64'd1);
    chk("l_busy", {63'd0, busy},     64'd0);
    send_byte(8'h00);
    chk("l_t0", {62'd0, frm_err, frm_valid}, 64'd0);
    send_byte(8'h11);
    chk("l_t1", {62'd0, frm_err, frm_valid}, 64'd0);
    chk("l_t1_busy", {63'd0, busy}, 64'd0);

    // Timeout: error lands exactly T cycles after the 0x10 strobe
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h10);
    repeat (T - 1) @(negedge clk);
    chk("t_early", {63'd0, frm_err}, 64'd0);
    chk("t_busy",  {63'd0, busy},    64'd1);
    @(negedge clk);
    chk("t_err",   {63'd0, frm_err}, 64'd1);
    chk("t_code",  {62'd0, err_code}, 64'd3);
    chk("t_idle",  {63'd0, busy},    64'd0);
    @(negedge clk);
    chk("t_pulse", {63'd0, frm_err}, 64'd0);

    // Strobe on the expiry cycle: byte wins, frame completes
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h10);
    repeat (T - 2) @(negedge clk);
    send_byte(8'h01);
    chk("te_noerr", {63'd0, frm_err}, 64'd0);
    chk("te_busy",  {63'd0, busy},    64'd1);
    send_byte(8'h7F); send_byte(8'h90);
    chk("te_valid", {63'd0, frm_valid}, 64'd1);
    chk("te_data",  frm_data,           64'h7F);

    // Header resync and wrapping checksum
    send_byte(8'hAA); send_byte(8'hAA); send_byte(8'h55); send_byte(8'h30);
    send_byte(8'h01); send_byte(8'hFF); send_byte(8'h30);
    chk("r_valid", {63'd0, frm_valid}, 64'd1);
    chk("r_cmd",   {56'd0, frm_cmd},   64'h30);
    chk("r_len",   {60'd0, frm_len},   64'd1);
    chk("r_data",  frm_data,           64'hFF);

    // Back-to-back frames with continuous strobes
    burst = '{8'hAA, 8'h55, 8'h50, 8'h00, 8'h50, 8'hAA, 8'h55, 8'h51, 8'h00, 8'h51};
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (frm_valid === 1'b1) pulses++;
      rx_byte  = burst[i];
      rx_valid = 1'b1;
    end
    @(negedge clk);
    if (frm_valid === 1'b1) pulses++;
    rx_valid = 1'b0;
    chk("b_pulses", 64'(pulses), 64'd2);
    chk("b_cmd",    {56'd0, frm_cmd}, 64'h51);

    // Reset during DATA discards the frame and clears outputs
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h40); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22);
    rst_n = 1'b0;
    #1;
    chk("ar_busy", {63'd0, busy}, 64'd0);
    repeat (2) @(negedge clk);
    chk("ar_flags", {61'd0, frm_valid, frm_err, busy}, 64'd0);
    chk("ar_cmd",   {56'd0, frm_cmd},  64'd0);
    chk("ar_data",  frm_data,          64'd0);
    chk("ar_code",  {62'd0, err_code}, 64'd0);
    rst_n = 1'b1;
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h41); send_byte(8'h01);
    send_byte(8'h02); send_byte(8'h44);
    chk("ar_valid", {63'd0, frm_valid}, 64'd1);
    chk("ar_cmd2",  {56'd0, frm_cmd},   64'h41);
    chk("ar_data2", frm_data,           64'h02);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_frame_ctrl.md
Name: uart_frame_ctrl

Overview:
Frame-level controller that sits directly behind the UART byte receiver. It consumes the receiver's byte strobe and data, and parses the framed command protocol: header, command, length, payload and checksum. It also enforces an inter-byte timeout. Complete, checked frames are presented to the command decoder as a single-cycle strobe with the frame contents held stable.

Parameters:
HDR0, 8'hAA, first header byte
HDR1, 8'h55, second header byte
MAX_LEN, 8, maximum payload bytes (frm_data width = 8*MAX_LEN)
TIMEOUT_CYC, 50000, clk cycles allowed between bytes inside a frame (about 11.5 byte times at 115200 baud / 50 MHz)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
rx_byte  input  8  received byte from UART receiver
rx_valid  input  1  one-cycle strobe; rx_byte valid this cycle
frm_cmd  output  8  command byte of last good frame
frm_len  output  4  payload length of last good frame
frm_data  output  8*MAX_LEN  payload of last good frame; byte i in bits [8i+7:8i]; unused bytes zero
frm_valid  output  1  one-cycle pulse: good frame accepted
frm_err  output  1  one-cycle pulse: frame aborted
err_code  output  2  1 = length > MAX_LEN, 2 = checksum mismatch, 3 = timeout; holds until next frm_err
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset is asynchronous, active-low, on rst_n; clock is clk. On reset, every output is 0, state = IDLE, and all counters and shadow registers are 0. Asserting reset mid-frame discards the partial frame and produces no pulse.
- Frame format: HDR0 HDR1 CMD LEN P0..P(LEN-1) CHK.
- CHK = (CMD + LEN + sum of Pi) mod 256, accumulated in an 8-bit wrapping sum.
- State machine: IDLE, HDR, CMD, LEN, DATA, CHK. All transitions occur only on cycles where rx_valid = 1, except the timeout abort.
  - IDLE: byte == HDR0 -> HDR. Any other byte is ignored.
  - HDR: byte == HDR1 -> CMD. byte == HDR0 -> stay in HDR (resync). Any other byte -> IDLE, with no error.
  - CMD: latch cmd into shadow; sum = byte; -> LEN.
  - LEN:
    - byte > MAX_LEN -> frm_err, err_code = 1, -> IDLE.
    - byte == 0 -> CHK.
    - Otherwise, latch length, clear shadow payload, byte index = 0, -> DATA.
    - In all non-error cases, sum += byte.
  - DATA: store byte at the current index; sum += byte; index++. When index reaches length-1 on this byte -> CHK.
  - CHK:
    - byte == sum -> copy shadow cmd/len/payload to the frm_* outputs, pulse frm_valid, -> IDLE.
    - Otherwise -> frm_err, err_code = 2, -> IDLE.
- Latency: frm_valid and frm_err are asserted on the clock edge following the rx_valid of the deciding byte, i.e. registered with 1-cycle latency. They are never asserted together.
- frm_cmd, frm_len and frm_data change only when a good frame is accepted; bad or aborted frames leave them untouched.
- Timeout:
  - The counter is cleared on every rx_valid and in IDLE, and increments every cycle otherwise.
  - When count == TIMEOUT_CYC-1 in any non-IDLE state -> frm_err, err_code = 3, -> IDLE.
  - If rx_valid coincides with timeout expiry, the byte wins: it is processed and the counter clears.
- Back-to-back: a byte arriving the cycle after the CHK byte is processed from IDLE; there are no dead cycles.
- rx_valid held high for multiple cycles is treated as multiple bytes. The upstream receiver guarantees single-cycle strobes.

Decomposition:
- Package uart_frame_pkg holds:
  - state enum encoding (3-bit);
  - err_code constants ERR_LEN = 2'd1, ERR_CHK = 2'd2, ERR_TMO = 2'd3;
  - default header constants.
- Sub-module frame_timeout: a cycle counter with clear/enable inputs and a one-cycle expiry output, parameterised by TIMEOUT_CYC. All other logic stays in the top module.

Test Plan:
- Good frame AA 55 10 02 12 34 58 -> frm_valid = 1 one cycle after the last strobe; frm_cmd = 0x10, frm_len = 2, frm_data[15:0] = 0x3412, upper bytes 0.
- Zero-length frame AA 55 20 00 20 -> frm_valid, frm_len = 0, frm_data all 0. Then a bad frame AA 55 10 01 05 00 -> frm_err, err_code = 2, frm_cmd still 0x20.
- Length violation AA 55 10 09 -> frm_err, err_code = 1 after the LEN byte. The following bytes 00 11 produce no pulse.
- Timeout: AA 55 10, then idle -> frm_err, err_code = 3 exactly TIMEOUT_CYC cycles after the 0x10 strobe, and busy falls. Repeat with a strobe landing on the expiry cycle -> no error.
- Resync: AA AA 55 30 01 FF 30 -> frm_valid, frm_cmd = 0x30, frm_data[7:0] = 0xFF (checksum wraps to 0x30).
- Reset asserted during DATA, then released, then a good frame -> no pulse during reset, all outputs 0; the subsequent frame is accepted normally.
